// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one step per cycle, pipeline held via stall_o.
module ex_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic                rem_neg_q, rem_neg_d;
  logic                done_q, done_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                is_div_in;
  logic                a_signed_in;
  logic                b_signed_in;
  logic                a_neg;
  logic                b_neg;
  logic [XLEN-1:0]     abs_a;
  logic [XLEN-1:0]     abs_b;
  logic                div_overflow;

  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       div_sh;
  logic [XLEN:0]       div_diff;
  logic                div_ge;
  logic [2*XLEN-1:0]   div_next;
  logic [2*XLEN-1:0]   step_acc;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix;
  logic [XLEN-1:0]     rem_fix;
  logic [XLEN-1:0]     final_result;

  // Operand conditioning: magnitudes plus the signs needed to correct the result.
  always_comb begin
    is_div_in   = funct3_i[2];
    a_signed_in = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                  (funct3_i == 3'b100) || (funct3_i == 3'b110);
    b_signed_in = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
    a_neg       = a_signed_in && op_a_i[XLEN-1];
    b_neg       = b_signed_in && op_b_i[XLEN-1];
    abs_a       = a_neg ? -op_a_i : op_a_i;
    abs_b       = b_neg ? -op_b_i : op_b_i;
    div_overflow = is_div_in && !funct3_i[0] &&
                   (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == {XLEN{1'b1}});
  end

  // acc holds {hi, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    div_ge   = !div_diff[XLEN];
    div_next = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    step_acc = funct3_q[2] ? div_next : mul_next;
  end

  always_comb begin
    prod_fix = neg_q ? -step_acc : step_acc;
    quo_fix  = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
    rem_fix  = rem_neg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
    case (funct3_q)
      3'b000:         final_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         final_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101: final_result = quo_fix;
      default:        final_result = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    funct3_d  = funct3_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    done_d    = 1'b0;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          funct3_d  = funct3_i;
          count_d   = '0;
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          opnd_d    = is_div_in ? abs_b : abs_a;
          acc_d     = {{XLEN{1'b0}}, (is_div_in ? abs_a : abs_b)};
          // Divide-by-zero and signed overflow finish without iterating.
          if (is_div_in && (op_b_i == '0)) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = funct3_i[1] ? op_a_i : {XLEN{1'b1}};
          end else if (div_overflow) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = funct3_i[1] ? {XLEN{1'b0}} : op_a_i;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        acc_d   = step_acc;
        count_d = count_q + CW'(1);
        if (count_q == CW'(XLEN-1)) begin
          state_d  = DONE;
          done_d   = 1'b1;
          count_d  = '0;
          result_d = final_result;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush_i) begin
      state_d  = IDLE;
      count_d  = '0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      funct3_q  <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      funct3_q  <= funct3_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign stall_o  = ((state_q == IDLE) && start_i) || (state_q == BUSY);
  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed, table-driven bench for ex_muldiv_seq: results, stall lengths, flush and reset corners.
module tb_ex_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int numChecks;
  int numFails;

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          stalls;
  } vec_t;

  vec_t vecs[18];

  ex_muldiv_seq #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (flush_i),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Presents an op at the next falling edge and holds it until done_o is seen after a rising edge.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output int stalls, output logic timeout);
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = f;
    op_a_i   = a;
    op_b_i   = b;
    stalls   = 0;
    timeout  = 1'b1;
    res      = 32'h0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (stall_o) stalls++;
      @(posedge clk);
      #1;
      if (done_o) begin
        res     = result_o;
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  logic [31:0] res;
  int          stalls;
  logic        timeout;
  logic        doneSeen;

  initial begin
    numChecks = 0;
    numFails  = 0;
    rst       = 1'b1;
    flush_i   = 1'b0;
    start_i   = 1'b0;
    funct3_i  = 3'b000;
    op_a_i    = 32'h0;
    op_b_i    = 32'h0;

    vecs[0]  = '{"MUL 7*-3",        3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{"MULH min*min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[2]  = '{"MULHU min*min",   3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[3]  = '{"MULHSU min*min",  3'b010, 32'h80000000, 32'h80000000, 32'hC0000000, 33};
    vecs[4]  = '{"DIV 100/0",       3'b100, 32'd100,      32'h00000000, 32'hFFFFFFFF, 1};
    vecs[5]  = '{"REMU 100/0",      3'b111, 32'd100,      32'h00000000, 32'd100,      1};
    vecs[6]  = '{"DIV min/-1",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[7]  = '{"REM min/-1",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[8]  = '{"REM -7%2",        3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[9]  = '{"DIV -7/2",        3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[10] = '{"DIVU big/2",      3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33};
    vecs[11] = '{"DIVU min/-1",     3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
    vecs[12] = '{"MUL x*16",        3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 33};
    vecs[13] = '{"MULH -1*-1",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
    vecs[14] = '{"MULHU max*max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[15] = '{"REM 7%-2",        3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 33};
    vecs[16] = '{"DIV 7/-2",        3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[17] = '{"REMU 100%7",      3'b111, 32'd100,      32'd7,        32'h00000002, 33};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy",   {31'h0, busy_o},  32'h0);
    checkOutput("reset done",   {31'h0, done_o},  32'h0);
    checkOutput("reset stall",  {31'h0, stall_o}, 32'h0);
    checkOutput("reset result", result_o,         32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].f, vecs[i].a, vecs[i].b, res, stalls, timeout);
      checkOutput({vecs[i].name, " timeout"}, {31'h0, timeout}, 32'h0);
      checkOutput({vecs[i].name, " result"}, res, vecs[i].res);
      checkOutput({vecs[i].name, " stalls"}, stalls, vecs[i].stalls);
      checkOutput({vecs[i].name, " stall in done"}, {31'h0, stall_o}, 32'h0);
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      checkOutput({vecs[i].name, " done pulse"}, {31'h0, done_o}, 32'h0);
      checkOutput({vecs[i].name, " idle after"}, {31'h0, busy_o}, 32'h0);
    end

    // Back-to-back: start stays high through DONE with the second op's operands.
    applyStimulus(3'b000, 32'd3, 32'd5, res, stalls, timeout);
    checkOutput("b2b MUL timeout", {31'h0, timeout}, 32'h0);
    checkOutput("b2b MUL result", res, 32'd15);
    applyStimulus(3'b101, 32'd100, 32'd7, res, stalls, timeout);
    checkOutput("b2b DIVU timeout", {31'h0, timeout}, 32'h0);
    checkOutput("b2b DIVU result", res, 32'd14);
    checkOutput("b2b DIVU stalls", stalls, 33);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);

    // Flush in the middle of a multiply: the result register keeps the previous value.
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = 3'b000;
    op_a_i   = 32'd7;
    op_b_i   = 32'd3;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("flush busy",   {31'h0, busy_o},  32'h0);
    checkOutput("flush stall",  {31'h0, stall_o}, 32'h0);
    checkOutput("flush done",   {31'h0, done_o},  32'h0);
    checkOutput("flush result", result_o,         32'd14);
    @(negedge clk);
    flush_i  = 1'b0;
    doneSeen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_o) doneSeen = 1'b1;
    end
    checkOutput("flush no done",   {31'h0, doneSeen}, 32'h0);
    checkOutput("flush held result", result_o,        32'd14);

    // Flush and start together in IDLE: nothing is accepted.
    @(negedge clk);
    flush_i  = 1'b1;
    start_i  = 1'b1;
    funct3_i = 3'b101;
    op_a_i   = 32'd100;
    op_b_i   = 32'd0;
    @(posedge clk);
    #1;
    checkOutput("flush+start busy",   {31'h0, busy_o}, 32'h0);
    checkOutput("flush+start done",   {31'h0, done_o}, 32'h0);
    checkOutput("flush+start result", result_o,        32'd14);
    @(negedge clk);
    flush_i = 1'b0;
    start_i = 1'b0;

    // Reset while BUSY clears the result and the state.
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = 3'b000;
    op_a_i   = 32'd7;
    op_b_i   = 32'd3;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("pre-reset busy", {31'h0, busy_o}, 32'h1);
    @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid reset busy",   {31'h0, busy_o}, 32'h0);
    checkOutput("mid reset done",   {31'h0, done_o}, 32'h0);
    checkOutput("mid reset result", result_o,        32'h0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(3'b000, 32'd7, 32'd3, res, stalls, timeout);
    checkOutput("post reset timeout", {31'h0, timeout}, 32'h0);
    checkOutput("post reset MUL", res, 32'd21);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
